// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state type for the instruction fetch stage
package fetch_pkg;
  localparam int INST_W = 9;
  localparam logic [INST_W-1:0] HALT_INST_DEF = 9'h1FF;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: next program counter selection (branch / start / increment / hold)
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int              IW         = 8,
  parameter logic [IW-1:0]   START_ADDR = '0
) (
  input  logic [IW-1:0] i_pc,
  input  logic          i_start,
  input  logic          i_branch,
  input  logic          i_rel,
  input  logic [IW-1:0] i_base,
  input  logic [IW-1:0] i_target,
  input  logic          i_inc,
  output logic [IW-1:0] o_pc_next
);
  logic [IW-1:0] w_rel_tgt;
  // An IW-bit two's-complement offset added modulo 2**IW equals the sign-extended sum truncated to IW bits
  always_comb begin
    w_rel_tgt = i_base + i_target;
    o_pc_next = i_branch ? (i_rel ? w_rel_tgt : i_target) :
                i_start  ? START_ADDR :
                i_inc    ? i_pc + 1'b1 : i_pc;
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and one-entry fetch register feeding decode; optional fetch counter via INST_FETCH_CNT_EN
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int                IW         = 8,
  parameter logic [IW-1:0]     START_ADDR = '0,
  parameter logic [INST_W-1:0] HALT_INST  = HALT_INST_DEF
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              start,
  output logic [IW-1:0]     inst_addr,
  input  logic [INST_W-1:0] inst_in,
  input  logic              branch_en,
  input  logic              branch_rel,
  input  logic [IW-1:0]     branch_base,
  input  logic [IW-1:0]     branch_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [IW-1:0]     if_pc,
`ifdef INST_FETCH_CNT_EN
  output logic [15:0]       fetch_count,
`endif
  output logic              halted
);
  fetch_state_t      r_state;
  logic [IW-1:0]     r_pc;
  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [IW-1:0]     r_if_pc;
  logic              r_halted;
  logic              w_start;
  logic              w_branch;
  logic              w_load;
  logic              w_is_halt;
  logic              w_drain_done;
  logic              w_accept;
  logic [IW-1:0]     w_pc_next;

  // Control decode: branch outranks everything; start only matters when fetch is stopped
  always_comb begin
    w_start      = (r_state == IDLE || r_state == HALT) && start;
    w_branch     = (r_state == RUN || r_state == DRAIN) && branch_en;
    w_load       = (r_state == RUN) && (!r_valid || if_ready) && !branch_en;
    w_is_halt    = inst_in == HALT_INST;
    w_drain_done = (r_state == DRAIN) && r_valid && if_ready && !branch_en;
    w_accept     = r_valid && if_ready && !w_branch;
  end

  fetch_pc_next #(.IW(IW), .START_ADDR(START_ADDR)) u_pc_next (
    .i_pc      (r_pc),
    .i_start   (w_start),
    .i_branch  (w_branch),
    .i_rel     (branch_rel),
    .i_base    (branch_base),
    .i_target  (branch_target),
    .i_inc     (w_load && !w_is_halt),
    .o_pc_next (w_pc_next)
  );

  // Fetch state machine and fetch register; a halt word parks the PC and waits for decode to take it
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_pc     <= START_ADDR;
      r_valid  <= 1'b0;
      r_inst   <= '0;
      r_if_pc  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_start) begin
        r_state  <= RUN;
        r_halted <= 1'b0;
        r_valid  <= 1'b0;
      end else if (w_branch) begin
        r_state <= RUN;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_inst  <= inst_in;
        r_if_pc <= r_pc;
        r_valid <= 1'b1;
        if (w_is_halt) r_state <= DRAIN;
      end else if (w_drain_done) begin
        r_valid  <= 1'b0;
        r_halted <= 1'b1;
        r_state  <= HALT;
      end
    end
  end

`ifdef INST_FETCH_CNT_EN
  logic [15:0] r_cnt;
  // Saturating count of instructions handed to decode; flushed entries never count
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) r_cnt <= '0;
    else r_cnt <= w_start ? 16'd0 : (w_accept && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
  end
  assign fetch_count = r_cnt;
`endif

  assign inst_addr = r_pc;
  assign if_valid  = r_valid;
  assign if_inst   = r_inst;
  assign if_pc     = r_if_pc;
  assign halted    = r_halted;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plus randomized checks of inst_fetch against a cycle-level behavioural model
module tb_inst_fetch;
  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic       branch_en = 1'b0;
  logic       branch_rel = 1'b0;
  logic       if_ready = 1'b0;
  logic [7:0] branch_base = '0;
  logic [7:0] branch_target = '0;
  logic [7:0] inst_addr;
  logic [7:0] if_pc;
  logic [8:0] inst_in;
  logic [8:0] if_inst;
  logic       if_valid;
  logic       halted;
`ifdef INST_FETCH_CNT_EN
  logic [15:0] fetch_count;
`endif
  logic [8:0] rom [256];
  int total = 0;
  int bad = 0;
  int m_st, m_pc, m_v, m_ins, m_ipc, m_hl, m_cnt;

  assign inst_in = rom[inst_addr];
  always #5 CLK = ~CLK;

  inst_fetch dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .inst_addr(inst_addr), .inst_in(inst_in),
    .branch_en(branch_en), .branch_rel(branch_rel), .branch_base(branch_base),
    .branch_target(branch_target), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc),
`ifdef INST_FETCH_CNT_EN
    .fetch_count(fetch_count),
`endif
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_v = 0; m_ins = 0; m_ipc = 0; m_hl = 0; m_cnt = 0;
  endtask

  // m_st: 0 idle, 1 running, 2 waiting for halt to drain, 3 halted
  task automatic model_step(input bit s, input bit rdy, input bit br, input bit rel, input int base, input int tgt);
    int off;
    bit acc;
    if ((m_st == 0 || m_st == 3) && s) begin
      m_st = 1; m_pc = 0; m_hl = 0; m_v = 0; m_cnt = 0;
    end else if ((m_st == 1 || m_st == 2) && br) begin
      off = (tgt > 127) ? tgt - 256 : tgt;
      m_pc = rel ? (base + off + 256) % 256 : tgt;
      m_v = 0; m_st = 1;
    end else begin
      acc = (m_v != 0) && rdy;
      if (acc && m_cnt < 65535) m_cnt++;
      if (m_st == 2 && acc) begin
        m_v = 0; m_hl = 1; m_st = 3;
      end else if (m_st == 1 && (m_v == 0 || rdy)) begin
        m_v = 1; m_ins = int'(rom[m_pc]); m_ipc = m_pc;
        if (m_ins == 'h1FF) m_st = 2;
        else m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    chk("if_valid", if_valid, m_v);
    chk("inst_addr", inst_addr, m_pc);
    chk("halted", halted, m_hl);
    if (m_v != 0) begin
      chk("if_inst", if_inst, m_ins);
      chk("if_pc", if_pc, m_ipc);
    end
`ifdef INST_FETCH_CNT_EN
    chk("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic cyc(input bit s, input bit rdy, input bit br, input bit rel, input logic [7:0] base, input logic [7:0] tgt);
    start = s; if_ready = rdy; branch_en = br; branch_rel = rel; branch_base = base; branch_target = tgt;
    model_step(s, rdy, br, rel, int'(base), int'(tgt));
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic areset();
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_pc", if_pc, 0);
    #2 Reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 'h1FE));
    rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h044; rom[4] = 9'h1FF;
    rom[8'h10] = 9'h0AA;
    model_reset();
    #3;
    check_all();
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_pc", if_pc, 0);
    #4 Reset_n = 1'b1;
    @(posedge CLK);
    #1;
    cyc(0, 1, 1, 0, 8'h00, 8'h30);
    chk("idle_ignores_branch", inst_addr, 0);
    // streaming fetch
    cyc(1, 1, 0, 0, 0, 0);
    chk("start_addr", inst_addr, 0);
    chk("start_valid", if_valid, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("first_inst", if_inst, 9'h011);
    cyc(0, 1, 0, 0, 0, 0);
    chk("second_inst", if_inst, 9'h022);
    // decode stall
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("stall_inst", if_inst, 9'h022);
      chk("stall_pc", if_pc, 1);
      chk("stall_addr", inst_addr, 2);
    end
    cyc(0, 1, 0, 0, 0, 0);
    chk("resume_inst", if_inst, 9'h033);
    // relative branches, including wrap below zero
    cyc(0, 1, 1, 1, 8'h05, 8'hFD);
    chk("rel_flush", if_valid, 0);
    chk("rel_addr", inst_addr, 2);
    cyc(0, 1, 0, 0, 0, 0);
    chk("rel_inst", if_inst, 9'h033);
    cyc(0, 1, 1, 1, 8'h01, 8'hFE);
    chk("rel_wrap", inst_addr, 8'hFF);
    // halt and drain
    cyc(0, 1, 1, 0, 8'h00, 8'h03);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("halt_inst", if_inst, 9'h1FF);
    chk("halt_pc_hold", inst_addr, 4);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_not_halted", halted, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("halted_set", halted, 1);
    chk("halted_invalid", if_valid, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("restart_clear", halted, 0);
    chk("restart_addr", inst_addr, 0);
    // branch cancels a pending halt
    cyc(0, 1, 1, 0, 8'h00, 8'h03);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("drain_pending", if_inst, 9'h1FF);
    cyc(0, 1, 1, 0, 8'h00, 8'h10);
    chk("drain_flush", if_valid, 0);
    chk("drain_flush_halted", halted, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("after_flush_inst", if_inst, 9'h0AA);
    // async reset mid-stream and the optional counter
    cyc(0, 1, 0, 0, 0, 0);
    areset();
    rom[4] = 9'h055;
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0);
`ifdef INST_FETCH_CNT_EN
    chk("count_five", fetch_count, 5);
`endif
    areset();
`ifdef INST_FETCH_CNT_EN
    chk("count_reset", fetch_count, 0);
`endif
    // randomized traffic with scattered halt words
    for (int i = 0; i < 10; i++) rom[$urandom_range(5, 255)] = 9'h1FF;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) areset();
      else cyc($urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
               1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly upstream of the 9-bit instruction ROM.
- Owns the program counter and drives the ROM read address.
- Captures the combinational ROM word into a one-entry fetch register and hands it to decode over a valid/ready handshake.
- Handles start, branch redirect/flush, and halt detection with a drain so the halt instruction reaches decode before the core stops.

Parameters:
- IW, 8: PC / ROM address width; ROM depth 2**IW.
- START_ADDR, 0: PC value loaded on reset and on every accepted start.
- HALT_INST, 9'h1FF: instruction encoding that ends fetch.

Ports:
- CLK, in, 1: clock, rising edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begin fetching at START_ADDR; honoured only in IDLE or HALT.
- inst_addr, out, IW: ROM read address; always equals the PC register.
- inst_in, in, 9: ROM data; combinational function of inst_addr.
- branch_en, in, 1: redirect request from execute.
- branch_rel, in, 1: 1 means relative target, 0 means absolute target.
- branch_base, in, IW: PC of the branching instruction; used when branch_rel=1.
- branch_target, in, IW: absolute target, or two's-complement offset when branch_rel=1.
- if_valid, out, 1: fetch register holds an instruction for decode.
- if_ready, in, 1: decode accepts the fetch register this cycle.
- if_inst, out, 9: fetched instruction.
- if_pc, out, IW: address if_inst was fetched from.
- halted, out, 1: HALT reached; halt instruction was consumed by decode.

Behaviour:
- Reset (async on Reset_n low): state=IDLE, pc=START_ADDR, if_valid=0, if_inst=0, if_pc=0, halted=0. On deassertion the block stays in IDLE until start. Reset mid-operation discards any in-flight instruction.
- States: IDLE, RUN, DRAIN, HALT.
- IDLE or HALT with start=1 → RUN. Same edge: pc=START_ADDR, halted=0, if_valid=0. branch_en is ignored in these states.
- load = (state==RUN) & (!if_valid | if_ready) & !branch_en.
- On load:
  - if_inst<=inst_in, if_pc<=pc, if_valid<=1.
  - If inst_in==HALT_INST: pc holds and state → DRAIN.
  - Otherwise pc<=pc+1, modulo 2**IW; 2**IW-1 wraps to 0 silently.
- RUN with if_valid & if_ready & !load cannot occur (load covers it). With if_valid & !if_ready, if_inst and if_pc are held stable and pc holds.
- DRAIN: no loads. When if_valid & if_ready: if_valid<=0, halted<=1, state → HALT.
- Branch (state RUN or DRAIN, branch_en=1):
  - Highest priority; overrides load and drain completion.
  - if_valid<=0 even if if_ready=1. The fetch-register entry is younger than the branch and is discarded.
  - pc <= branch_rel ? branch_base + sign-extended branch_target (mod 2**IW) : branch_target.
  - state → RUN; a halt captured in DRAIN is cancelled.
- start in RUN or DRAIN is ignored.
- Latency:
  - start at edge t: inst_addr=START_ADDR after t; if_valid=1 with rom[START_ADDR] after t+1.
  - Branch at edge t: if_valid=0 after t; target instruction valid after t+1.
- Back-to-back throughput is one instruction per cycle while if_ready=1.
- halted stays 1 until the next accepted start.

Optional Feature:
- Macro: INST_FETCH_CNT_EN.
- Defined:
  - Adds output fetch_count, 16 bits.
  - Increments on each if_valid & if_ready; saturates at 16'hFFFF.
  - Reset to 0 by Reset_n and by accepted start.
  - Flushed instructions are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - INST_W=9 constant.
  - Default HALT_INST constant.
  - typedef enum logic[1:0] fetch_state_t {IDLE, RUN, DRAIN, HALT}.
- One sub-module, fetch_pc_next: combinational next-PC selection (hold / +1 / absolute / base+offset) with the sign-extension and wrap rules above.
- The state machine and fetch register stay in inst_fetch.

Test Plan:
1. Reset then start, ROM[0..2]=9'h011,9'h022,9'h033, if_ready=1 → if_inst 011,022,033 on consecutive cycles; if_pc 0,1,2.
2. if_ready=0 for 3 cycles while if_valid holds 022 → if_inst=022 and if_pc=1 stable; inst_addr=2 held; resumes with 033 after if_ready=1.
3. Relative branch: branch_en=1, branch_rel=1, branch_base=8'h05, branch_target=8'hFD (−3) → next cycle if_valid=0 and inst_addr=2; ROM[2] valid one cycle later. Repeat with branch_base=8'h01, branch_target=8'hFE → inst_addr=8'hFF (wrap).
4. Halt: ROM[4]=9'h1FF → fetch stops with pc=4 and state DRAIN. Hold if_ready=0 for 2 cycles → halted=0. Accept → halted=1, if_valid=0. start → refetch from START_ADDR.
5. Branch while in DRAIN with halt pending → halt flushed, never presented to decode, halted stays 0, fetch resumes at target.
6. Reset_n asserted mid-stream with if_valid=1 → immediately if_valid=0, inst_addr=START_ADDR, halted=0. With INST_FETCH_CNT_EN defined, 5 accepts then reset → fetch_count goes 5 then 0.
